// File: rtl/data_mem_load_unit.sv
// data_mem_load_unit: load engine over a byte-select sync-read data memory; MISALIGNED_LOAD_EN enables misaligned/spanning loads
module data_mem_load_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic [3:0]            mem_byte_sel,
  input  logic [31:0]           mem_rd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic                  rsp_misaligned
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD_LO  = 3'd1;
  localparam logic [2:0] CAP_LO = 3'd2;
  localparam logic [2:0] RESP   = 3'd4;
  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0]            size;
  logic                  uns;
  logic [ADDR_WIDTH-1:0] lo_addr;
  logic [31:0]           raw;
  logic [31:0]           ext;
  assign lo_addr   = {addr[ADDR_WIDTH-1:2], 2'b00};
  assign req_ready = rst_n && state == IDLE;
  assign rsp_valid = state == RESP;
  assign ext = size == 2'd0 ? {{24{~uns & raw[7]}}, raw[7:0]} :
               size == 2'd1 ? {{16{~uns & raw[15]}}, raw[15:0]} : raw;
`ifdef MISALIGNED_LOAD_EN
  localparam logic [2:0] CAP_HI = 3'd3;
  logic [7:0]  mask;
  logic        span;
  logic [31:0] lo_word;
  logic [63:0] win;
  assign mask = (size == 2'd0 ? 8'h01 : size == 2'd1 ? 8'h03 : 8'h0f) << addr[1:0];
  assign span = |mask[7:4];
  assign win  = state == CAP_HI ? {mem_rd_data, lo_word} : {32'h0, mem_rd_data};
  assign raw  = 32'(win >> {addr[1:0], 3'b000});
  assign rsp_misaligned = 1'b0;
  always_comb begin
    mem_rd_en    = state == RD_LO || (state == CAP_LO && span);
    mem_rd_addr  = state == RD_LO ? lo_addr : mem_rd_en ? lo_addr + ADDR_WIDTH'(4) : '0;
    mem_byte_sel = state == RD_LO ? mask[3:0] : mem_rd_en ? mask[7:4] : 4'h0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rsp_data <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr     <= req_addr;
          size     <= req_size;
          uns      <= req_unsigned;
          rsp_data <= '0;
          state    <= RD_LO;
        end
        RD_LO: state <= CAP_LO;
        CAP_LO: begin
          lo_word <= mem_rd_data;
          if (!span) rsp_data <= ext;
          state <= span ? CAP_HI : RESP;
        end
        CAP_HI: begin
          rsp_data <= ext;
          state    <= RESP;
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic [3:0] mask;
  logic       mis_req;
  assign mask    = (size == 2'd0 ? 4'h1 : size == 2'd1 ? 4'h3 : 4'hf) << addr[1:0];
  assign mis_req = (req_size == 2'd1 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
  assign raw     = mem_rd_data >> {addr[1:0], 3'b000};
  always_comb begin
    mem_rd_en    = state == RD_LO;
    mem_rd_addr  = mem_rd_en ? lo_addr : '0;
    mem_byte_sel = mem_rd_en ? mask : 4'h0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      rsp_data       <= '0;
      rsp_misaligned <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr           <= req_addr;
          size           <= req_size;
          uns            <= req_unsigned;
          rsp_data       <= '0;
          rsp_misaligned <= mis_req;
          state          <= mis_req ? RESP : RD_LO;
        end
        RD_LO: state <= CAP_LO;
        CAP_LO: begin
          rsp_data <= ext;
          state    <= RESP;
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`endif
endmodule

// File: tb/tb_data_mem_load_unit.sv
// tb_data_mem_load_unit: randomized and directed loads checked against a byte-level reference model
module tb_data_mem_load_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        mem_rd_en;
  logic [31:0] mem_rd_addr;
  logic [3:0]  mem_byte_sel;
  logic [31:0] mem_rd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_misaligned;
  int n_cmp = 0;
  int n_fail = 0;
  logic [35:0] rd_q[$];

  data_mem_load_unit #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_byte_sel(mem_byte_sel),
    .mem_rd_data(mem_rd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_misaligned(rsp_misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] w);
    case (w)
      32'h0000_0100: return 32'h8899AABB;
      32'h0000_0104: return 32'h44332211;
      32'hFFFF_FFFC: return 32'h77000000;
      32'h0000_0000: return 32'h000000E5;
      default:       return (w * 32'h9E3779B1) ^ 32'h5BD1E995;
    endcase
  endfunction

  always @(posedge clk) mem_rd_data <= mem_rd_en ? word_at(mem_rd_addr) : 32'hDEADBEEF;
  always @(negedge clk) if (mem_rd_en) rd_q.push_back({mem_rd_addr, mem_byte_sel});

  task automatic ref_model(input logic [31:0] a, input logic [1:0] sz, input logic u,
                           output logic [31:0] d, output logic mis, output int nrd,
                           output logic [71:0] rdv, output int lat);
    int n;
    logic [31:0] ba, lo;
    logic [3:0] sl, sh;
    logic [7:0] b;
    logic m;
    n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    m = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
    lo = a & ~32'h3;
    d = 0; sl = 0; sh = 0;
    for (int i = 0; i < n; i++) begin
      ba = a + i;
      b = 8'(word_at(ba & ~32'h3) >> (8 * ba[1:0]));
      d |= 32'(b) << (8 * i);
      if ((ba & ~32'h3) == lo) sl[ba[1:0]] = 1'b1;
      else sh[ba[1:0]] = 1'b1;
    end
    if (n < 4 && !u && d[8*n-1]) d |= ~32'h0 << (8 * n);
`ifdef MISALIGNED_LOAD_EN
    mis = 1'b0;
    nrd = sh != 0 ? 2 : 1;
    rdv = {lo, sl, sh != 0 ? {lo + 32'd4, sh} : 36'h0};
    lat = nrd == 2 ? 4 : 3;
`else
    mis = m;
    nrd = m ? 0 : 1;
    rdv = m ? 72'h0 : {lo, sl, 36'h0};
    lat = m ? 1 : 3;
    if (m) d = 0;
`endif
  endtask

  // Starts and ends on a falling edge; lat counts rising edges from acceptance to rsp_valid.
  task automatic run_load(input logic [31:0] a, input logic [1:0] sz, input logic u, input int hold,
                          input logic pend, input logic [31:0] pa, input logic [1:0] psz,
                          output int waitc, output int lat, output logic [31:0] d, output logic mis,
                          output int nrd, output logic [71:0] rdv, output logic unstable,
                          output logic rdy_busy);
    req_valid = 1'b1; req_addr = a; req_size = sz; req_unsigned = u;
    rd_q.delete();
    waitc = 0;
    while (!req_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    if (pend) begin
      req_addr = pa; req_size = psz; req_unsigned = 1'b0;
    end else req_valid = 1'b0;
    rdy_busy = 1'b0;
    while (!rsp_valid && lat < 20) begin
      rdy_busy |= req_ready;
      @(negedge clk);
      lat++;
    end
    d = rsp_data; mis = rsp_misaligned; unstable = 1'b0;
    nrd = rd_q.size();
    rdv = {nrd > 0 ? rd_q[0] : 36'h0, nrd > 1 ? rd_q[1] : 36'h0};
    repeat (hold) begin
      rdy_busy |= req_ready;
      @(negedge clk);
      unstable |= rsp_data !== d || rsp_misaligned !== mis || rsp_valid !== 1'b1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = 0; req_size = 0; req_unsigned = 0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
    n_cmp++;
    if ({rsp_valid, rsp_misaligned, rsp_data} !== 34'h0)
      begin n_fail++; $display("FAIL reset_rsp got v=%b m=%b d=%h want 0", rsp_valid, rsp_misaligned, rsp_data); end
    n_cmp++;
    if ({mem_rd_en, mem_rd_addr, mem_byte_sel} !== 37'h0)
      begin n_fail++; $display("FAIL reset_mem got en=%b a=%h s=%b want 0", mem_rd_en, mem_rd_addr, mem_byte_sel); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %b want 1", req_ready); end
  endtask

  task automatic test_aligned;
    logic [31:0] ta[3] = '{32'h103, 32'h102, 32'h100};
    logic [1:0]  ts[3] = '{2'd0, 2'd1, 2'd1};
    logic        tu[3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] td[3] = '{32'hFFFFFF88, 32'h00008899, 32'hFFFFAABB};
    logic [3:0]  tl[3] = '{4'b1000, 4'b1100, 4'b0011};
    int w, lat, nrd;
    logic [31:0] d;
    logic mis, un, rb;
    logic [71:0] rdv;
    for (int i = 0; i < 3; i++) begin
      run_load(ta[i], ts[i], tu[i], 0, 1'b0, 0, 0, w, lat, d, mis, nrd, rdv, un, rb);
      n_cmp++;
      if (d !== td[i]) begin n_fail++; $display("FAIL aligned_data[%0d] got %h want %h", i, d, td[i]); end
      n_cmp++;
      if (lat !== 3) begin n_fail++; $display("FAIL aligned_latency[%0d] got %0d want 3", i, lat); end
      n_cmp++;
      if (nrd !== 1 || rdv !== {32'h100, tl[i], 36'h0})
        begin n_fail++; $display("FAIL aligned_reads[%0d] got n=%0d %h want 1 %h", i, nrd, rdv, {32'h100, tl[i], 36'h0}); end
      n_cmp++;
      if (mis !== 1'b0) begin n_fail++; $display("FAIL aligned_mis[%0d] got %b want 0", i, mis); end
    end
  endtask

  task automatic test_misaligned;
    logic [31:0] ta[2] = '{32'h102, 32'hFFFFFFFF};
    logic [1:0]  ts[2] = '{2'd2, 2'd1};
`ifdef MISALIGNED_LOAD_EN
    logic [31:0] td[2] = '{32'h22118899, 32'hFFFFE577};
    logic [71:0] tr[2] = '{{32'h100, 4'b1100, 32'h104, 4'b0011}, {32'hFFFFFFFC, 4'b1000, 32'h0, 4'b0001}};
    int tn = 2, tl = 4;
    logic tm = 1'b0;
`else
    logic [31:0] td[2] = '{32'h0, 32'h0};
    logic [71:0] tr[2] = '{72'h0, 72'h0};
    int tn = 0, tl = 1;
    logic tm = 1'b1;
`endif
    int w, lat, nrd;
    logic [31:0] d;
    logic mis, un, rb;
    logic [71:0] rdv;
    for (int i = 0; i < 2; i++) begin
      run_load(ta[i], ts[i], 1'b0, 0, 1'b0, 0, 0, w, lat, d, mis, nrd, rdv, un, rb);
      n_cmp++;
      if (d !== td[i] || mis !== tm)
        begin n_fail++; $display("FAIL misaligned_rsp[%0d] got %h/%b want %h/%b", i, d, mis, td[i], tm); end
      n_cmp++;
      if (lat !== tl) begin n_fail++; $display("FAIL misaligned_latency[%0d] got %0d want %0d", i, lat, tl); end
      n_cmp++;
      if (nrd !== tn || rdv !== tr[i])
        begin n_fail++; $display("FAIL misaligned_reads[%0d] got n=%0d %h want %0d %h", i, nrd, rdv, tn, tr[i]); end
    end
  endtask

  task automatic test_back_to_back;
    int w, lat, nrd;
    logic [31:0] d;
    logic mis, un, rb;
    logic [71:0] rdv;
    run_load(32'h104, 2'd2, 1'b0, 3, 1'b1, 32'h100, 2'd2, w, lat, d, mis, nrd, rdv, un, rb);
    n_cmp++;
    if (d !== 32'h44332211) begin n_fail++; $display("FAIL b2b_first_data got %h want 44332211", d); end
    n_cmp++;
    if (un !== 1'b0) begin n_fail++; $display("FAIL b2b_hold_stable got unstable=%b want 0", un); end
    n_cmp++;
    if (rb !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_busy got %b want 0", rb); end
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      begin n_fail++; $display("FAIL b2b_after_handshake got v=%b r=%b want 0/1", rsp_valid, req_ready); end
    run_load(32'h100, 2'd2, 1'b0, 0, 1'b0, 0, 0, w, lat, d, mis, nrd, rdv, un, rb);
    n_cmp++;
    if (w !== 0 || d !== 32'h8899AABB)
      begin n_fail++; $display("FAIL b2b_second got wait=%0d d=%h want 0 8899aabb", w, d); end
  endtask

  task automatic test_reset_mid_op;
    logic seen = 1'b0;
`ifdef MISALIGNED_LOAD_EN
    req_addr = 32'hFFFFFFFF; req_size = 2'd1;
`else
    req_addr = 32'h104; req_size = 2'd2;
`endif
    req_valid = 1'b1; req_unsigned = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
`ifdef MISALIGNED_LOAD_EN
    if (mem_rd_en !== 1'b1 || mem_rd_addr !== 32'h0 || mem_byte_sel !== 4'b0001)
      begin n_fail++; $display("FAIL midrst_hi_read got en=%b a=%h s=%b want 1 0 0001", mem_rd_en, mem_rd_addr, mem_byte_sel); end
`else
    if (mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL midrst_cap_lo_en got %b want 0", mem_rd_en); end
`endif
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_rd_en !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0)
      begin n_fail++; $display("FAIL midrst_in_reset got en=%b v=%b r=%b want 0", mem_rd_en, rsp_valid, req_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_idle got ready=%b want 1", req_ready); end
    repeat (6) begin
      seen |= rsp_valid | mem_rd_en;
      @(negedge clk);
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_no_rsp got activity=%b want 0", seen); end
  endtask

  task automatic test_random;
    logic [31:0] bases[4];
    logic [31:0] a, d, ed;
    logic [1:0] sz;
    logic u, mis, em, un, rb;
    logic [71:0] rdv, erdv;
    int w, lat, nrd, enrd, elat, hold;
    for (int i = 0; i < 60; i++) begin
      bases = '{32'h100, 32'hFFFFFFF8, 32'h0, $urandom};
      a = bases[$urandom_range(0, 3)] + 32'($urandom_range(0, 7));
      sz = 2'($urandom);
      u = 1'($urandom);
      hold = $urandom_range(0, 2);
      ref_model(a, sz, u, ed, em, enrd, erdv, elat);
      run_load(a, sz, u, hold, 1'b0, 0, 0, w, lat, d, mis, nrd, rdv, un, rb);
      n_cmp++;
      if (d !== ed || mis !== em)
        begin n_fail++; $display("FAIL rand_rsp[%0d] a=%h sz=%0d u=%b got %h/%b want %h/%b", i, a, sz, u, d, mis, ed, em); end
      n_cmp++;
      if (lat !== elat) begin n_fail++; $display("FAIL rand_latency[%0d] a=%h sz=%0d got %0d want %0d", i, a, sz, lat, elat); end
      n_cmp++;
      if (nrd !== enrd || rdv !== erdv)
        begin n_fail++; $display("FAIL rand_reads[%0d] a=%h sz=%0d got %0d %h want %0d %h", i, a, sz, nrd, rdv, enrd, erdv); end
      n_cmp++;
      if (un !== 1'b0 || rb !== 1'b0 || rsp_valid !== 1'b0)
        begin n_fail++; $display("FAIL rand_protocol[%0d] got unstable=%b busy_ready=%b v=%b want 0", i, un, rb, rsp_valid); end
    end
  endtask

  initial begin
    test_reset;
    test_aligned;
    test_misaligned;
    test_back_to_back;
    test_reset_mid_op;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout after %0d compared", n_cmp);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/data_mem_load_unit.md
# data_mem_load_unit

Read-side companion to the data memory's byte-select write port. Accepts load requests from the execute stage via valid/ready, issues one or two word-aligned reads with a `byte_sel_t` mask to a synchronous-read data memory, and extracts, merges and sign/zero-extends the addressed byte, half or word. The result is returned over a valid/ready response channel to writeback.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte-address width; `mem_rd_addr` uses the same width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  load request valid.
- `req_ready`  out  1  request accepted when both `req_valid` and `req_ready` are high.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- `req_unsigned`  in  1  1 = zero-extend, 0 = sign-extend; ignored for word loads.
- `mem_rd_en`  out  1  read strobe to data memory.
- `mem_rd_addr`  out  ADDR_WIDTH  word-aligned address; bits [1:0] are always 0.
- `mem_byte_sel`  out  4 (`byte_sel_t`)  bytes of the word belonging to this load.
- `mem_rd_data`  in  32  read data, valid the cycle after `mem_rd_en`.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumed when both `rsp_valid` and `rsp_ready` are high.
- `rsp_data`  out  32  extended load result.
- `rsp_misaligned`  out  1  misaligned load rejected; only produced when `MISALIGNED_LOAD_EN` is undefined.

## Operation
- States:
  - `IDLE`: `req_ready`=1.
  - `RD_LO`: read the low word.
  - `CAP_LO`: capture the low word; issue the high read if the load spans two words.
  - `CAP_HI`: capture the high word.
  - `RESP`: hold the response.
- Request fields (addr, size, unsigned) are latched on acceptance.
- Offset `o = addr[1:0]`; byte count `n` = 1, 2 or 4.
  - Misaligned: half with `o[0]`=1, or word with `o`≠0.
  - Spanning: `o + n > 4`.
- Transitions:
  - `IDLE` → `RD_LO` on handshake.
  - `RD_LO` → `CAP_LO`.
  - `CAP_LO` → `CAP_HI` if spanning, else → `RESP`.
  - `CAP_HI` → `RESP`.
  - `RESP` → `IDLE` on response handshake.
- Low read:
  - `mem_rd_addr = {addr[ADDR_WIDTH-1:2],2'b00}`.
  - `mem_byte_sel` has bits `o` through `min(o+n,4)-1` set.
- High read (issued in `CAP_LO`):
  - Address is the low address + 4, modulo 2^ADDR_WIDTH (wraps to 0).
  - `mem_byte_sel` has bits 0 through `o+n-5` set.
- Assembly: low-word bytes `o..3` become result bytes `0..`, followed by high-word bytes. Little-endian throughout.
- Extension: byte/half are extended per `req_unsigned` to 32 bits; word is passed through.
- `mem_rd_en` is high only in `RD_LO`, and in `CAP_LO` when spanning. `mem_rd_addr`/`mem_byte_sel` are 0 otherwise.
- `mem_rd_data` is sampled only in `CAP_LO` and `CAP_HI`.
- One load in flight; `req_ready`=0 outside `IDLE`.

## Timing
- Reset values: state `IDLE`, `rsp_valid`=0, `rsp_data`=0, `rsp_misaligned`=0, `mem_rd_en`=0, `mem_rd_addr`=0, `mem_byte_sel`=0. `req_ready`=1 from the first cycle after reset deasserts; it is 0 while `rst_n`=0.
- Request accepted in cycle N:
  - Non-spanning load: `rsp_valid` rises in N+3.
  - Spanning load: `rsp_valid` rises in N+4.
- `rsp_data` and `rsp_misaligned` are registered and stable while `rsp_valid && !rsp_ready`.
- Earliest next acceptance is the cycle after the response handshake (`IDLE`); there is no combinational ready path.
- Reset mid-operation (any state): next cycle is `IDLE`, in-flight read data is discarded, and no response is produced.
- Request while `rsp_valid` is held: not accepted until after the handshake.

## Configuration
- `MISALIGNED_LOAD_EN` defined:
  - Misaligned loads are performed.
  - Non-spanning misaligned loads (e.g. half at offset 1) use one read.
  - Spanning loads use two reads.
  - `rsp_misaligned` is tied 0.
- `MISALIGNED_LOAD_EN` undefined:
  - A misaligned request goes `IDLE` → `RESP` directly with `rsp_data`=0 and `rsp_misaligned`=1.
  - No `mem_rd_en` is issued; `rsp_valid` rises in N+1.
  - `CAP_HI` and the merge logic are not built.

## Test plan
Memory preload: word 0x100 = 0x8899AABB, word 0x104 = 0x44332211, word 0xFFFFFFFC = 0x77000000, word 0x0 = 0x000000E5.
- LB signed @0x103 → one read 0x100 sel 1000; `rsp_data`=0xFFFFFF88, `rsp_valid` at N+3.
- LHU @0x102 → sel 1100; `rsp_data`=0x00008899. LH signed @0x100 → 0xFFFFAABB.
- LW @0x102:
  - Macro on: reads 0x100 sel 1100 then 0x104 sel 0011; `rsp_data`=0x22118899 at N+4.
  - Macro off: no reads; `rsp_data`=0, `rsp_misaligned`=1 at N+1.
- LH signed @0xFFFFFFFF (macro on) → reads 0xFFFFFFFC sel 1000 then 0x00000000 sel 0001; `rsp_data`=0xFFFFE577.
- LW @0x104 with `rsp_ready` low for 3 cycles → `rsp_data`=0x44332211 held stable, `req_ready`=0, and a second pending request is accepted only after the handshake.
- `rst_n` low for one cycle during `CAP_LO` of a spanning load → next cycle `IDLE`, `mem_rd_en`=0, no `rsp_valid` ever produced for that load.
